id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised decode stage with an integrated ID/EX pipeline register, a register file of configurable depth, and a load-use hazard detector.
- Decodes the instruction presented by IF and reads operands.
- Registers the decoded bundle toward EX under a valid/ready handshake.
- Inserts bubbles on load-use hazards; honours a branch flush from EX.
- Counts stall cycles for performance monitoring.
- Sits between the IF stage and the EX stage of the pipelined core.

Parameters:
DATA_WIDTH, 32, width of data, PC and immediate paths
REG_NUM, 32, number of architectural registers (power of two, >=2); AW = clog2(REG_NUM)
STALL_CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
if_valid  in  1  IF presents a valid instruction
if_instr  in  32  instruction word
if_pc  in  DATA_WIDTH  PC of if_instr
id_ready  out  1  ID accepts if_instr this cycle
ex_ready  in  1  EX accepts the ID/EX register contents this cycle
flush  in  1  EX-resolved redirect; kill the ID/EX entry
wb_we  in  1  writeback enable
wb_rd  in  AW  writeback register address
wb_data  in  DATA_WIDTH  writeback data
ex_valid  out  1  ID/EX entry valid
ex_pc  out  DATA_WIDTH  registered PC
ex_rs1_data, ex_rs2_data  out  DATA_WIDTH  registered operands
ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  AW  registered register addresses (instr fields truncated to AW)
ex_imm  out  DATA_WIDTH  registered sign-extended immediate (I/S/B/U/J per opcode)
ex_funct3  out  3  registered funct3
ex_funct7  out  7  registered funct7
ex_opcode  out  7  registered opcode
ex_reg_write, ex_dm_read, ex_dm_write, ex_branch  out  1 each  registered control bits
ex_illegal  out  1  registered: opcode not in the RV32I base set
stall_cnt  out  STALL_CNT_W  number of load-use bubble cycles

Behaviour:
Reset (rst low, async):
- All ex_* outputs 0.
- stall_cnt 0.
- All registers 0.

Register file:
- REG_NUM x DATA_WIDTH.
- Entry 0 always reads 0.
- Written at posedge when wb_we=1 and wb_rd!=0.
- Reads are combinational from if_instr[19:15] and if_instr[24:20].

Decode (combinational on if_instr):
- uses_rs1: every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- uses_rs2: only R 0110011, S 0100011 and B 1100011.
- reg_write: set for R, I-ALU 0010011, LOAD 0000011, LUI, AUIPC, JAL and JALR 1100111.
- Also set for any opcode when rd=0; EX/WB ignore writes to x0.
- dm_read = LOAD; dm_write = S; branch = B.

Load-use hazard:
- load_use = ex_valid & ex_dm_read & ex_rd_addr!=0 & if_valid & ((uses_rs1 & rs1==ex_rd_addr) | (uses_rs2 & rs2==ex_rd_addr)).

Handshake:
- id_ready = flush | (ex_ready & ~load_use).

ID/EX update at posedge, evaluated in priority order:
1. flush: ex_valid<=0, ex_reg_write<=0, ex_dm_write<=0. Flush wins over a simultaneous load_use or ex_ready=0.
2. ex_ready & load_use: insert a bubble (ex_valid, ex_reg_write, ex_dm_read, ex_dm_write, ex_branch <= 0). IF holds its instruction; stall_cnt increments.
3. ex_ready & ~load_use: capture the decoded bundle; ex_valid<=if_valid.
4. ~ex_ready: hold all ID/EX contents.

Other rules:
- Latency: 1 cycle from acceptance to ex_valid.
- A bubble lasts exactly 1 cycle: the load advances out of EX, so load_use deasserts.
- stall_cnt saturates at all-ones; it does not wrap.
- Data fields of a bubble or flushed entry are don't-care, but control bits must be 0.

Optional Feature:
ID_WB_BYPASS_EN:
- Defined: if wb_we=1, wb_rd!=0 and wb_rd equals a source address, that operand takes wb_data in the same cycle (write-through read).
- Undefined: the register file returns the pre-write value. The core then needs EX-side forwarding from WB.

Test Plan:
- Reset: drive rst=0 mid-run with ex_valid=1 -> all ex_* and stall_cnt read 0 immediately (async), id_ready=ex_ready after release.
- Back-to-back ADDI x1,x0,5 then ADD x2,x1,x1 with wb_we/wb_rd=1/wb_data=5 in the second decode cycle:
  - Bypass defined -> ex_rs1_data=ex_rs2_data=5.
  - Bypass undefined -> both 0.
- Load-use: LW x3,0(x0) then ADD x4,x3,x0 -> one cycle id_ready=0 and ex_valid=0 bubble, stall_cnt=1, ADD issued next cycle. LW x3 followed by LUI x5 -> no stall.
- Flush and load_use asserted together -> ex_valid=0, stall_cnt unchanged, id_ready=1.
- Backpressure: ex_ready=0 for 3 cycles with a valid entry -> ex_* stable, id_ready=0. Entry advances once ex_ready=1.
- Write to x0 (wb_we=1, wb_rd=0, data 0xDEADBEEF), then read x0 -> 0. Force 2^STALL_CNT_W+2 load-use stalls -> stall_cnt stays at all-ones.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: ID/EX pipeline bundle driven by decode, with EX-side ready and redirect flush.
interface id_stage_pipe_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned AW         = 5
);
   logic                  ex_valid;
   logic                  ex_ready;
   logic                  flush;
   logic [DATA_WIDTH-1:0] ex_pc;
   logic [DATA_WIDTH-1:0] ex_rs1_data;
   logic [DATA_WIDTH-1:0] ex_rs2_data;
   logic [AW-1:0]         ex_rs1_addr;
   logic [AW-1:0]         ex_rs2_addr;
   logic [AW-1:0]         ex_rd_addr;
   logic [DATA_WIDTH-1:0] ex_imm;
   logic [2:0]            ex_funct3;
   logic [6:0]            ex_funct7;
   logic [6:0]            ex_opcode;
   logic                  ex_reg_write;
   logic                  ex_dm_read;
   logic                  ex_dm_write;
   logic                  ex_branch;
   logic                  ex_illegal;

   modport master (
      output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
             ex_rd_addr, ex_imm, ex_funct3, ex_funct7, ex_opcode, ex_reg_write,
             ex_dm_read, ex_dm_write, ex_branch, ex_illegal,
      input  ex_ready, flush
   );

   modport slave (
      input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
             ex_rd_addr, ex_imm, ex_funct3, ex_funct7, ex_opcode, ex_reg_write,
             ex_dm_read, ex_dm_write, ex_branch, ex_illegal,
      output ex_ready, flush
   );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode with register file, load-use bubble insertion and ID/EX register.
// Optional macro ID_WB_BYPASS_EN: operands read through a same-cycle writeback (write-through regfile).
module id_stage_pipe #(
   parameter  int unsigned DATA_WIDTH  = 32,
   parameter  int unsigned REG_NUM     = 32,
   parameter  int unsigned STALL_CNT_W = 16,
   localparam int unsigned AW          = $clog2(REG_NUM)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_valid,
   input  logic [31:0]            if_instr,
   input  logic [DATA_WIDTH-1:0]  if_pc,
   output logic                   id_ready,
   input  logic                   wb_we,
   input  logic [AW-1:0]          wb_rd,
   input  logic [DATA_WIDTH-1:0]  wb_data,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   id_stage_pipe_if.master        ex
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [DATA_WIDTH-1:0] regs [REG_NUM];

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [AW-1:0]         rs1_addr;
   logic [AW-1:0]         rs2_addr;
   logic [AW-1:0]         rd_addr;
   logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
   logic signed [31:0]    imm32;
   logic [DATA_WIDTH-1:0] imm;
   logic                  uses_rs1, uses_rs2;
   logic                  reg_write, dm_read, dm_write, branch, illegal;
   logic [DATA_WIDTH-1:0] rf_rs1, rf_rs2;
   logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
   logic                  load_use;

   assign opcode   = if_instr[6:0];
   assign funct3   = if_instr[14:12];
   assign funct7   = if_instr[31:25];
   assign rs1_addr = AW'(if_instr[19:15]);
   assign rs2_addr = AW'(if_instr[24:20]);
   assign rd_addr  = AW'(if_instr[11:7]);

   assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                   if_instr[11:8], 1'b0};
   assign imm_u = {if_instr[31:12], 12'b0};
   assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                   if_instr[30:21], 1'b0};
   assign imm   = DATA_WIDTH'(imm32);

   // Opcode decode; writes to x0 are flagged as register writes and dropped downstream.
   always_comb begin : decode
      uses_rs1  = 1'b1;
      uses_rs2  = 1'b0;
      reg_write = (if_instr[11:7] == 5'd0);
      dm_read   = 1'b0;
      dm_write  = 1'b0;
      branch    = 1'b0;
      illegal   = 1'b0;
      imm32     = imm_i;
      case (opcode)
         OP_LUI, OP_AUIPC: begin
            uses_rs1  = 1'b0;
            reg_write = 1'b1;
            imm32     = imm_u;
         end
         OP_JAL: begin
            uses_rs1  = 1'b0;
            reg_write = 1'b1;
            imm32     = imm_j;
         end
         OP_JALR, OP_OPIMM: reg_write = 1'b1;
         OP_BRANCH: begin
            uses_rs2 = 1'b1;
            branch   = 1'b1;
            imm32    = imm_b;
         end
         OP_LOAD: begin
            reg_write = 1'b1;
            dm_read   = 1'b1;
         end
         OP_STORE: begin
            uses_rs2 = 1'b1;
            dm_write = 1'b1;
            imm32    = imm_s;
         end
         OP_OP: begin
            uses_rs2  = 1'b1;
            reg_write = 1'b1;
         end
         OP_FENCE, OP_SYSTEM: begin
         end
         default: illegal = 1'b1;
      endcase
   end

   // Register file write port; entry 0 is never written.
   always_ff @(posedge clk or negedge rst) begin : rf_write
      if (!rst) begin
         for (int unsigned i = 0; i < REG_NUM; i++) begin
            regs[AW'(i)] <= '0;
         end
      end else if (wb_we && (wb_rd != '0)) begin
         regs[wb_rd] <= wb_data;
      end
   end

   assign rf_rs1 = (rs1_addr == '0) ? '0 : regs[rs1_addr];
   assign rf_rs2 = (rs2_addr == '0) ? '0 : regs[rs2_addr];

`ifdef ID_WB_BYPASS_EN
   assign rs1_data = (wb_we && (wb_rd != '0) && (wb_rd == rs1_addr)) ? wb_data : rf_rs1;
   assign rs2_data = (wb_we && (wb_rd != '0) && (wb_rd == rs2_addr)) ? wb_data : rf_rs2;
`else
   assign rs1_data = rf_rs1;
   assign rs2_data = rf_rs2;
`endif

   assign load_use = ex.ex_valid && ex.ex_dm_read && (ex.ex_rd_addr != '0) && if_valid &&
                     ((uses_rs1 && (rs1_addr == ex.ex_rd_addr)) ||
                      (uses_rs2 && (rs2_addr == ex.ex_rd_addr)));

   assign id_ready = ex.flush || (ex.ex_ready && !load_use);

   // ID/EX register: flush > bubble > capture > hold.
   always_ff @(posedge clk or negedge rst) begin : id_ex_reg
      if (!rst) begin
         ex.ex_valid     <= 1'b0;
         ex.ex_pc        <= '0;
         ex.ex_rs1_data  <= '0;
         ex.ex_rs2_data  <= '0;
         ex.ex_rs1_addr  <= '0;
         ex.ex_rs2_addr  <= '0;
         ex.ex_rd_addr   <= '0;
         ex.ex_imm       <= '0;
         ex.ex_funct3    <= '0;
         ex.ex_funct7    <= '0;
         ex.ex_opcode    <= '0;
         ex.ex_reg_write <= 1'b0;
         ex.ex_dm_read   <= 1'b0;
         ex.ex_dm_write  <= 1'b0;
         ex.ex_branch    <= 1'b0;
         ex.ex_illegal   <= 1'b0;
         stall_cnt       <= '0;
      end else if (ex.flush || (ex.ex_ready && load_use)) begin
         ex.ex_valid     <= 1'b0;
         ex.ex_reg_write <= 1'b0;
         ex.ex_dm_read   <= 1'b0;
         ex.ex_dm_write  <= 1'b0;
         ex.ex_branch    <= 1'b0;
         ex.ex_illegal   <= 1'b0;
         if (!ex.flush && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
         end
      end else if (ex.ex_ready) begin
         ex.ex_valid     <= if_valid;
         ex.ex_pc        <= if_pc;
         ex.ex_rs1_data  <= rs1_data;
         ex.ex_rs2_data  <= rs2_data;
         ex.ex_rs1_addr  <= rs1_addr;
         ex.ex_rs2_addr  <= rs2_addr;
         ex.ex_rd_addr   <= rd_addr;
         ex.ex_imm       <= imm;
         ex.ex_funct3    <= funct3;
         ex.ex_funct7    <= funct7;
         ex.ex_opcode    <= opcode;
         ex.ex_reg_write <= if_valid && reg_write;
         ex.ex_dm_read   <= if_valid && dm_read;
         ex.ex_dm_write  <= if_valid && dm_write;
         ex.ex_branch    <= if_valid && branch;
         ex.ex_illegal   <= if_valid && illegal;
      end
   end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed and random checks of id_stage_pipe against a spec-level decode/pipeline model.
module tb_id_stage_pipe;
   localparam int unsigned SCW = 4;
   localparam logic [31:0] STALL_MAX = 32'((1 << SCW) - 1);
`ifdef ID_WB_BYPASS_EN
   localparam logic [31:0] BYP_EXP = 32'd5;
`else
   localparam logic [31:0] BYP_EXP = 32'd0;
`endif

   localparam logic [31:0] I_ADDI1 = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] I_ADD2  = 32'h00108133; // add  x2,x1,x1
   localparam logic [31:0] I_LW3   = 32'h00002183; // lw   x3,0(x0)
   localparam logic [31:0] I_ADD4  = 32'h00018233; // add  x4,x3,x0
   localparam logic [31:0] I_LUI5  = 32'h000182B7; // lui  x5 (rs1 field = 3)
   localparam logic [31:0] I_ADD6  = 32'h00000333; // add  x6,x0,x0

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [SCW-1:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state: what EX should be holding.
   logic        m_valid, m_ctrl;
   logic [31:0] m_pc, m_d1, m_d2, m_imm;
   logic [4:0]  m_a1, m_a2, m_rd;
   logic [2:0]  m_f3;
   logic [6:0]  m_f7, m_op;
   logic        m_rw, m_dr, m_dw, m_br, m_ill;
   logic [31:0] m_stall;
   logic [31:0] m_rf [32];

   id_stage_pipe_if #(.DATA_WIDTH(32), .AW(5)) ex_bus ();

   id_stage_pipe #(.DATA_WIDTH(32), .REG_NUM(32), .STALL_CNT_W(SCW)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_valid  (if_valid),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .id_ready  (id_ready),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .stall_cnt (stall_cnt),
      .ex        (ex_bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   function automatic void decode(input logic [31:0] ins, output logic u1, output logic u2,
                                  output logic rw, output logic dr, output logic dw,
                                  output logic br, output logic ill, output logic [31:0] imm);
      logic [6:0] op;
      op  = ins[6:0];
      u1  = !(op inside {7'h37, 7'h17, 7'h6f});
      u2  = op inside {7'h33, 7'h23, 7'h63};
      rw  = (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6f, 7'h67}) || (ins[11:7] == 5'd0);
      dr  = (op == 7'h03);
      dw  = (op == 7'h23);
      br  = (op == 7'h63);
      ill = !(op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                         7'h0f, 7'h73});
      case (op)
         7'h23: imm = 32'(($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
         7'h63: imm = 32'(($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11) |
                      (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
         7'h37, 7'h17: imm = ins & 32'hFFFFF000;
         7'h6f: imm = 32'(($signed(ins) >>> 31) << 20) | (32'(ins[19:12]) << 12) |
                      (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
         default: imm = 32'($signed(ins) >>> 20);
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_ctrl = 1; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
      m_a1 = 0; m_a2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_op = 0;
      m_rw = 0; m_dr = 0; m_dw = 0; m_br = 0; m_ill = 0; m_stall = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
   endtask

   task automatic check_ex();
      chk("ex_valid", 32'(ex_bus.ex_valid), 32'(m_valid));
      if (m_ctrl) begin
         chk("ex_reg_write", 32'(ex_bus.ex_reg_write), 32'(m_rw));
         chk("ex_dm_read",   32'(ex_bus.ex_dm_read),   32'(m_dr));
         chk("ex_dm_write",  32'(ex_bus.ex_dm_write),  32'(m_dw));
         chk("ex_branch",    32'(ex_bus.ex_branch),    32'(m_br));
      end
      if (m_valid) begin
         chk("ex_pc",       ex_bus.ex_pc,       m_pc);
         chk("ex_rs1_data", ex_bus.ex_rs1_data, m_d1);
         chk("ex_rs2_data", ex_bus.ex_rs2_data, m_d2);
         chk("ex_rs1_addr", 32'(ex_bus.ex_rs1_addr), 32'(m_a1));
         chk("ex_rs2_addr", 32'(ex_bus.ex_rs2_addr), 32'(m_a2));
         chk("ex_rd_addr",  32'(ex_bus.ex_rd_addr),  32'(m_rd));
         chk("ex_imm",      ex_bus.ex_imm,      m_imm);
         chk("ex_funct3",   32'(ex_bus.ex_funct3),  32'(m_f3));
         chk("ex_funct7",   32'(ex_bus.ex_funct7),  32'(m_f7));
         chk("ex_opcode",   32'(ex_bus.ex_opcode),  32'(m_op));
         chk("ex_illegal",  32'(ex_bus.ex_illegal), 32'(m_ill));
      end
      chk("stall_cnt", 32'(stall_cnt), m_stall);
   endtask

   // One clock: drive, check id_ready, clock, advance the model, check EX.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd);
      logic u1, u2, rw, dr, dw, br, ill, hz;
      logic [31:0] imm, d1, d2;
      logic [4:0] a1, a2;
      @(negedge clk);
      if_valid = v; if_instr = ins; if_pc = pc;
      ex_bus.ex_ready = rdy; ex_bus.flush = fl;
      wb_we = we; wb_rd = wrd; wb_data = wd;
      decode(ins, u1, u2, rw, dr, dw, br, ill, imm);
      a1 = ins[19:15];
      a2 = ins[24:20];
      d1 = m_rf[a1];
      d2 = m_rf[a2];
`ifdef ID_WB_BYPASS_EN
      if (we && wrd != 0 && wrd == a1) d1 = wd;
      if (we && wrd != 0 && wrd == a2) d2 = wd;
`endif
      hz = m_valid && m_dr && (m_rd != 0) && v && ((u1 && a1 == m_rd) || (u2 && a2 == m_rd));
      #1;
      chk("id_ready", 32'(id_ready), 32'(fl || (rdy && !hz)));
      @(posedge clk);
      #1;
      if (we && wrd != 0) m_rf[wrd] = wd;
      if (fl || (rdy && hz)) begin
         m_valid = 0; m_rw = 0; m_dr = 0; m_dw = 0; m_br = 0; m_ctrl = 1;
         if (!fl && m_stall != STALL_MAX) m_stall++;
      end else if (rdy) begin
         m_valid = v; m_ctrl = v; m_pc = pc; m_d1 = d1; m_d2 = d2;
         m_a1 = a1; m_a2 = a2; m_rd = ins[11:7]; m_imm = imm;
         m_f3 = ins[14:12]; m_f7 = ins[31:25]; m_op = ins[6:0];
         m_rw = rw; m_dr = dr; m_dw = dw; m_br = br; m_ill = ill;
      end
      check_ex();
   endtask

   initial begin
      logic [6:0] ops [12];
      logic [31:0] ins;
      ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73, 7'h03};

      rst = 0; if_valid = 0; if_instr = 0; if_pc = 0;
      ex_bus.ex_ready = 0; ex_bus.flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
      model_reset();
      #1;
      chk("rst_ex_valid", 32'(ex_bus.ex_valid), 0);
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_pc", ex_bus.ex_pc, 0);
      chk("rst_reg_write", 32'(ex_bus.ex_reg_write), 0);
      @(negedge clk); @(negedge clk);
      rst = 1;

      // Back-to-back ADDI / ADD with writeback of x1 during the ADD decode.
      cycle(1, I_ADDI1, 32'h100, 1, 0, 0, 0, 0);
      cycle(1, I_ADD2,  32'h104, 1, 0, 1, 1, 32'd5);
      chk("byp_rs1", ex_bus.ex_rs1_data, BYP_EXP);
      chk("byp_rs2", ex_bus.ex_rs2_data, BYP_EXP);

      // Load-use: one bubble, then the dependent ADD issues.
      cycle(1, I_LW3,  32'h110, 1, 0, 0, 0, 0);
      cycle(1, I_ADD4, 32'h114, 1, 0, 0, 0, 0);
      chk("lu_bubble_valid", 32'(ex_bus.ex_valid), 0);
      chk("lu_stall", 32'(stall_cnt), 1);
      cycle(1, I_ADD4, 32'h114, 1, 0, 0, 0, 0);
      chk("lu_issue_valid", 32'(ex_bus.ex_valid), 1);
      chk("lu_issue_rd", 32'(ex_bus.ex_rd_addr), 4);

      // LUI does not read rs1, so no stall behind the load.
      cycle(1, I_LW3,  32'h120, 1, 0, 0, 0, 0);
      cycle(1, I_LUI5, 32'h124, 1, 0, 0, 0, 0);
      chk("lui_valid", 32'(ex_bus.ex_valid), 1);
      chk("lui_stall", 32'(stall_cnt), 1);

      // Flush together with load-use.
      cycle(1, I_LW3,  32'h130, 1, 0, 0, 0, 0);
      cycle(1, I_ADD4, 32'h134, 1, 1, 0, 0, 0);
      chk("fl_valid", 32'(ex_bus.ex_valid), 0);
      chk("fl_stall", 32'(stall_cnt), 1);

      // Backpressure: three held cycles, then advance.
      cycle(1, I_ADDI1, 32'h200, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, I_ADD2, 32'h204, 0, 0, 0, 0, 0);
      chk("bp_hold_pc", ex_bus.ex_pc, 32'h200);
      cycle(1, I_ADD2, 32'h204, 1, 0, 0, 0, 0);
      chk("bp_adv_pc", ex_bus.ex_pc, 32'h204);

      // Writes to x0 are discarded.
      cycle(0, 32'h0, 32'h0, 1, 0, 1, 0, 32'hDEADBEEF);
      cycle(1, I_ADD6, 32'h300, 1, 0, 1, 0, 32'hDEADBEEF);
      chk("x0_rs1", ex_bus.ex_rs1_data, 0);
      chk("x0_rs2", ex_bus.ex_rs2_data, 0);

      // Stall counter saturation.
      for (int i = 0; i < (1 << SCW) + 2; i++) begin
         cycle(1, I_LW3,  32'h400, 1, 0, 0, 0, 0);
         cycle(1, I_ADD4, 32'h404, 1, 0, 0, 0, 0);
         cycle(1, I_ADD4, 32'h404, 1, 0, 0, 0, 0);
      end
      chk("stall_sat", 32'(stall_cnt), STALL_MAX);

      // Asynchronous reset mid-run with a valid entry in EX.
      cycle(1, I_LW3, 32'h500, 1, 0, 0, 0, 0);
      @(negedge clk);
      #2;
      rst = 0;
      #1;
      chk("arst_valid", 32'(ex_bus.ex_valid), 0);
      chk("arst_dm_read", 32'(ex_bus.ex_dm_read), 0);
      chk("arst_stall", 32'(stall_cnt), 0);
      chk("arst_rd", 32'(ex_bus.ex_rd_addr), 0);
      model_reset();
      @(negedge clk);
      rst = 1; if_valid = 1; if_instr = I_ADD4; ex_bus.flush = 0; ex_bus.ex_ready = 0;
      #1;
      chk("rel_ready0", 32'(id_ready), 0);
      ex_bus.ex_ready = 1;
      #1;
      chk("rel_ready1", 32'(id_ready), 1);
      ex_bus.ex_ready = 0;
      if_valid = 0;

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         ins = $urandom;
         ins[6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
         ins[11:7]  = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         cycle(1'($urandom_range(0, 4) != 0), ins, $urandom,
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
